parity_frame_rx: RTL and testbench

- Serial frame receiver that checks XOR parity; it is the receiving end of the team's XOR-parity serial link.
- Accepts one line bit per qualified clock in this order: start, DATA_W data bits (LSB first), parity, stop.
- Outputs the deframed word with a one-cycle valid strobe, plus parity-error and framing-error flags.
- Sits between the link sampler (which supplies bit_vld and bit_in) and the word-level consumer.

---
 rtl/parity_frame_rx_if.sv | 33 +++
 rtl/parity_frame_rx.sv | 111 +++++++++++
 tb/tb_parity_frame_rx.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/parity_frame_rx_if.sv
// Link-side and word-side signals of the XOR-parity frame receiver.
// The master modport is the link sampler/consumer side; the slave modport is the receiver.
interface parity_frame_rx_if #(
    parameter int DATA_W = 8
);
    logic              bit_vld;
    logic              bit_in;
    logic [DATA_W-1:0] data_out;
    logic              data_vld;
    logic              parity_err;
    logic              frame_err;
    logic              busy;

    modport master (
        output bit_vld,
        output bit_in,
        input  data_out,
        input  data_vld,
        input  parity_err,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  bit_vld,
        input  bit_in,
        output data_out,
        output data_vld,
        output parity_err,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/parity_frame_rx.sv
// Receiver for start / DATA_W data bits (LSB first) / XOR parity / stop frames.
// Produces registered one-cycle strobes after the stop bit is sampled.
module parity_frame_rx #(
    parameter int DATA_W     = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic             clk,
    input  logic             rst,
    parity_frame_rx_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic ODD = (PARITY_ODD != 0);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [DATA_W-1:0] shift_reg, shift_next;
    logic              acc_reg, acc_next;
    logic              perr_reg, perr_next;
    logic [DATA_W-1:0] data_out_reg, data_out_next;
    logic              data_vld_reg, data_vld_next;
    logic              parity_err_reg, parity_err_next;
    logic              frame_err_reg, frame_err_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            shift_reg      <= '0;
            acc_reg        <= 1'b0;
            perr_reg       <= 1'b0;
            data_out_reg   <= '0;
            data_vld_reg   <= 1'b0;
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            shift_reg      <= shift_next;
            acc_reg        <= acc_next;
            perr_reg       <= perr_next;
            data_out_reg   <= data_out_next;
            data_vld_reg   <= data_vld_next;
            parity_err_reg <= parity_err_next;
            frame_err_reg  <= frame_err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        shift_next      = shift_reg;
        acc_next        = acc_reg;
        perr_next       = perr_reg;
        data_out_next   = data_out_reg;
        // Strobes always fall back to 0, even on cycles without a qualified bit.
        data_vld_next   = 1'b0;
        parity_err_next = 1'b0;
        frame_err_next  = 1'b0;

        if (bus.bit_vld) begin
            unique case (state_reg)
                IDLE: begin
                    if (!bus.bit_in) begin
                        state_next = DATA;
                        cnt_next   = '0;
                        shift_next = '0;
                        acc_next   = 1'b0;
                    end
                end
                DATA: begin
                    // Counter doubles as the bit position, so bit k lands in data bit k.
                    shift_next[cnt_reg] = bus.bit_in;
                    acc_next            = acc_reg ^ bus.bit_in;
                    cnt_next            = cnt_reg + CNT_W'(1);
                    if (cnt_reg == LAST_BIT) begin
                        state_next = PARITY;
                    end
                end
                PARITY: begin
                    perr_next  = acc_reg ^ bus.bit_in ^ ODD;
                    state_next = STOP;
                end
                STOP: begin
                    if (bus.bit_in) begin
                        data_out_next   = shift_reg;
                        data_vld_next   = 1'b1;
                        parity_err_next = perr_reg;
                    end else begin
                        frame_err_next  = 1'b1;
                    end
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign bus.data_out   = data_out_reg;
    assign bus.data_vld   = data_vld_reg;
    assign bus.parity_err = parity_err_reg;
    assign bus.frame_err  = frame_err_reg;
    assign bus.busy       = (state_reg != IDLE);
endmodule

// File: tb/tb_parity_frame_rx.sv
// Bench for parity_frame_rx: an even-parity and an odd-parity instance driven by directed
// frames, with a frame-level expectation model checked every cycle plus literal spot checks.
module tb_parity_frame_rx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1;
    parity_frame_rx_if #(.DATA_W(8)) if0 ();
    parity_frame_rx_if #(.DATA_W(8)) if1 ();

    parity_frame_rx #(.DATA_W(8), .PARITY_ODD(0)) u_even (
        .clk (clk),
        .rst (rst0),
        .bus (if0.slave)
    );
    parity_frame_rx #(.DATA_W(8), .PARITY_ODD(1)) u_odd (
        .clk (clk),
        .rst (rst1),
        .bus (if1.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Expected outputs, derived from whole-frame outcomes.
    logic       m_busy[2], m_vld[2], m_perr[2], m_ferr[2];
    logic [7:0] m_data[2];

    logic       a_busy[2], a_vld[2], a_perr[2], a_ferr[2];
    logic [7:0] a_data[2];
    assign a_busy[0] = if0.busy;       assign a_busy[1] = if1.busy;
    assign a_vld[0]  = if0.data_vld;   assign a_vld[1]  = if1.data_vld;
    assign a_perr[0] = if0.parity_err; assign a_perr[1] = if1.parity_err;
    assign a_ferr[0] = if0.frame_err;  assign a_ferr[1] = if1.frame_err;
    assign a_data[0] = if0.data_out;   assign a_data[1] = if1.data_out;

    typedef enum {EV_NONE, EV_START, EV_STOP, EV_RST} ev_t;
    ev_t        pend      = EV_NONE;
    int         pend_sel  = 0;
    logic       pend_stop = 1'b1;
    logic       pend_perr = 1'b0;
    logic [7:0] pend_word = 8'h00;

    logic       chk_en = 1'b0;
    int         vld_cnt[2];
    logic [7:0] rx_q1[$];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                cmp($sformatf("inst%0d busy", i),       32'(a_busy[i]), 32'(m_busy[i]));
                cmp($sformatf("inst%0d data_vld", i),   32'(a_vld[i]),  32'(m_vld[i]));
                cmp($sformatf("inst%0d parity_err", i), 32'(a_perr[i]), 32'(m_perr[i]));
                cmp($sformatf("inst%0d frame_err", i),  32'(a_ferr[i]), 32'(m_ferr[i]));
                cmp($sformatf("inst%0d data_out", i),   32'(a_data[i]), 32'(m_data[i]));
                if (a_vld[i] === 1'b1) begin
                    vld_cnt[i]++;
                    if (i == 1) rx_q1.push_back(a_data[i]);
                end
            end
        end
    end

    // One clock of stimulus: first retire the effect of the bit sampled at this edge,
    // then present the next bit to the selected instance.
    task automatic step(input int sel, input logic vld, input logic b, input logic r,
                        input ev_t ev, input logic [7:0] word, input logic pe);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            m_vld[i]  = 1'b0;
            m_perr[i] = 1'b0;
            m_ferr[i] = 1'b0;
        end
        case (pend)
            EV_START: m_busy[pend_sel] = 1'b1;
            EV_STOP: begin
                m_busy[pend_sel] = 1'b0;
                if (pend_stop) begin
                    m_vld[pend_sel]  = 1'b1;
                    m_perr[pend_sel] = pend_perr;
                    m_data[pend_sel] = pend_word;
                end else begin
                    m_ferr[pend_sel] = 1'b1;
                end
            end
            EV_RST: begin
                m_busy[pend_sel] = 1'b0;
                m_data[pend_sel] = 8'h00;
            end
            default: ;
        endcase
        if0.bit_vld = (sel == 0) && vld;
        if0.bit_in  = (sel == 0) ? b : 1'b1;
        if1.bit_vld = (sel == 1) && vld;
        if1.bit_in  = (sel == 1) ? b : 1'b1;
        rst0 = (sel == 0) && r;
        rst1 = (sel == 1) && r;
        pend      = ev;
        pend_sel  = sel;
        pend_stop = b;
        pend_word = word;
        pend_perr = pe;
    endtask

    task automatic gap(input int sel, input int maxgap);
        int n;
        n = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
        for (int k = 0; k < n; k++) step(sel, 1'b0, 1'b1, 1'b0, EV_NONE, 8'h00, 1'b0);
    endtask

    task automatic send_frame(input int sel, input logic [7:0] word, input logic pbit,
                              input logic stop, input int maxgap);
        logic pe;
        pe = (^word) ^ pbit ^ (sel == 1);
        gap(sel, maxgap);
        step(sel, 1'b1, 1'b0, 1'b0, EV_START, 8'h00, 1'b0);
        for (int k = 0; k < 8; k++) begin
            gap(sel, maxgap);
            step(sel, 1'b1, word[k], 1'b0, EV_NONE, 8'h00, 1'b0);
        end
        gap(sel, maxgap);
        step(sel, 1'b1, pbit, 1'b0, EV_NONE, 8'h00, 1'b0);
        gap(sel, maxgap);
        step(sel, 1'b1, stop, 1'b0, EV_STOP, word, pe);
    endtask

    task automatic idle(input int sel, input int n);
        for (int k = 0; k < n; k++) step(sel, 1'b0, 1'b1, 1'b0, EV_NONE, 8'h00, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 1'b0; m_vld[i] = 1'b0; m_perr[i] = 1'b0; m_ferr[i] = 1'b0;
            m_data[i] = 8'h00; vld_cnt[i] = 0;
        end
        if0.bit_vld = 1'b0; if0.bit_in = 1'b1;
        if1.bit_vld = 1'b0; if1.bit_in = 1'b1;
        rst0 = 1'b1; rst1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst0 = 1'b0; rst1 = 1'b0;
        chk_en = 1'b1;
        idle(0, 2);

        // Good even-parity frame.
        send_frame(0, 8'hA5, 1'b0, 1'b1, 0);
        idle(0, 1);
        @(negedge clk);
        cmp("a5_data", 32'(if0.data_out), 32'h0000_00A5);
        cmp("a5_vld", 32'(if0.data_vld), 32'd1);
        cmp("a5_perr", 32'(if0.parity_err), 32'd0);
        idle(0, 2);

        // Same word, wrong parity: still delivered, flagged.
        send_frame(0, 8'hA5, 1'b1, 1'b1, 0);
        idle(0, 1);
        @(negedge clk);
        cmp("a5_bad_perr", 32'(if0.parity_err), 32'd1);
        cmp("a5_bad_vld", 32'(if0.data_vld), 32'd1);
        idle(0, 2);

        // Bad stop bit: no word, data_out holds.
        send_frame(0, 8'h3C, 1'b0, 1'b0, 0);
        idle(0, 1);
        @(negedge clk);
        cmp("ferr_flag", 32'(if0.frame_err), 32'd1);
        cmp("ferr_vld", 32'(if0.data_vld), 32'd0);
        cmp("ferr_hold", 32'(if0.data_out), 32'h0000_00A5);
        cmp("ferr_busy", 32'(if0.busy), 32'd0);
        idle(0, 2);

        // Idle ones, then a frame with random gaps between bits.
        for (int k = 0; k < 10; k++) step(0, 1'b1, 1'b1, 1'b0, EV_NONE, 8'h00, 1'b0);
        send_frame(0, 8'h5A, 1'b0, 1'b1, 5);
        idle(0, 1);
        @(negedge clk);
        cmp("gap_data", 32'(if0.data_out), 32'h0000_005A);
        cmp("gap_perr", 32'(if0.parity_err), 32'd0);
        idle(0, 3);
        cmp("gap_pulses", 32'(vld_cnt[0]), 32'd3);

        // Reset mid-frame, then a clean frame.
        step(0, 1'b1, 1'b0, 1'b0, EV_START, 8'h00, 1'b0);
        step(0, 1'b1, 1'b1, 1'b0, EV_NONE, 8'h00, 1'b0);
        step(0, 1'b1, 1'b0, 1'b0, EV_NONE, 8'h00, 1'b0);
        step(0, 1'b1, 1'b1, 1'b0, EV_NONE, 8'h00, 1'b0);
        step(0, 1'b0, 1'b1, 1'b1, EV_RST, 8'h00, 1'b0);
        idle(0, 1);
        @(negedge clk);
        cmp("rst_busy", 32'(if0.busy), 32'd0);
        cmp("rst_data", 32'(if0.data_out), 32'd0);
        idle(0, 2);
        send_frame(0, 8'h3C, 1'b0, 1'b1, 0);
        idle(0, 1);
        @(negedge clk);
        cmp("rst_after_data", 32'(if0.data_out), 32'h0000_003C);
        cmp("rst_after_vld", 32'(if0.data_vld), 32'd1);
        idle(0, 2);

        // Odd parity instance, back-to-back frames.
        idle(1, 2);
        send_frame(1, 8'h00, 1'b1, 1'b1, 0);
        send_frame(1, 8'hFF, 1'b1, 1'b1, 0);
        idle(1, 4);

        cmp("even_pulses", 32'(vld_cnt[0]), 32'd4);
        cmp("odd_pulses", 32'(vld_cnt[1]), 32'd2);
        cmp("odd_q_size", 32'(rx_q1.size()), 32'd2);
        if (rx_q1.size() == 2) begin
            cmp("odd_word0", 32'(rx_q1[0]), 32'h0000_0000);
            cmp("odd_word1", 32'(rx_q1[1]), 32'h0000_00FF);
        end

        chk_en = 1'b0;
        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
